// File: rtl/calc_pkg.sv
// Shared constants and enums for the calculator port issuer.
package calc_pkg;

  localparam int unsigned CALC_CMD_W  = 4;
  localparam int unsigned CALC_DATA_W = 32;
  localparam int unsigned CALC_TAG_W  = 2;

  typedef enum logic [CALC_CMD_W-1:0] {
    CmdNop = 4'd0,
    CmdAdd = 4'd1,
    CmdSub = 4'd2,
    CmdShl = 4'd5,
    CmdShr = 4'd6
  } calc_cmd_e;

  typedef enum logic [1:0] {
    RespNone    = 2'd0,
    RespOk      = 2'd1,
    RespOvf     = 2'd2,
    RespInvalid = 2'd3
  } calc_resp_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StOp2  = 1'b1
  } issuer_state_e;

endpackage

// File: rtl/calc_tag_alloc.sv
// Tag table busy tracking: lowest-free allocation, occupancy count and, with
// CALC_TIMEOUT_EN defined, per-tag response watchdogs.
module calc_tag_alloc
  import calc_pkg::*;
#(
  parameter int unsigned NUM_TAGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  PClk,
  input  logic                  reset,
  input  logic                  alloc,
  input  logic                  free_req,
  input  logic [CALC_TAG_W-1:0] free_req_tag,
  output logic [NUM_TAGS-1:0]   busy,
  output logic                  free_avail,
  output logic [CALC_TAG_W-1:0] free_tag,
  output logic [2:0]            count,
  output logic                  to_valid,
  output logic [CALC_TAG_W-1:0] to_tag
);

  logic [NUM_TAGS-1:0] busy_q, busy_d;

  assign busy = busy_q;

  // Allocation looks only at registered state, so a tag freed this cycle
  // becomes allocatable one cycle later.
  always_comb begin
    free_tag   = '0;
    free_avail = ~&busy_q;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_tag = CALC_TAG_W'(i);
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      count = count + 3'(busy_q[i]);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (alloc)    busy_d[free_tag]     = 1'b1;
    if (free_req) busy_d[free_req_tag] = 1'b0;
    if (to_valid) busy_d[to_tag]       = 1'b0;
  end

  always_ff @(posedge PClk) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0]     cnt_q [NUM_TAGS];
  logic [CntW-1:0]     cnt_d [NUM_TAGS];
  logic [NUM_TAGS-1:0] expired;

  // An expired tag waits while any real response completes this cycle; a
  // response to the expired tag itself frees it and cancels the timeout.
  always_comb begin
    expired = '0;
    to_tag  = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      expired[i] = busy_q[i] && (cnt_q[i] == CntMax);
    end
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (expired[i]) to_tag = CALC_TAG_W'(i);
    end
    to_valid = (|expired) && !free_req;
  end

  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (alloc && (free_tag == CALC_TAG_W'(i))) begin
        cnt_d[i] = '0;
      end else if (busy_q[i] && !expired[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge PClk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_valid           = 1'b0;
  assign to_tag             = '0;
`endif

endmodule

// File: rtl/calc_port_issuer.sv
// Calculator port request issuer: tags requests, drives the two-cycle
// cmd/operand sequence and matches responses. CALC_TIMEOUT_EN adds watchdogs.
module calc_port_issuer
  import calc_pkg::*;
#(
  parameter int unsigned CMD_W          = CALC_CMD_W,
  parameter int unsigned DATA_W         = CALC_DATA_W,
  parameter int unsigned NUM_TAGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              PClk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic [CMD_W-1:0]  PCmd,
  output logic [DATA_W-1:0] PData,
  output logic [1:0]        PTag,
  input  logic [1:0]        out_resp,
  input  logic [DATA_W-1:0] out_data,
  input  logic [1:0]        out_tag,
  output logic              cpl_valid,
  output logic [1:0]        cpl_resp,
  output logic [DATA_W-1:0] cpl_data,
  output logic [1:0]        cpl_tag,
  output logic [CMD_W-1:0]  cpl_cmd,
  output logic [2:0]        outstanding,
  output logic              spurious_err
);

  issuer_state_e state_q, state_d;

  logic [CMD_W-1:0]      pcmd_q, pcmd_d;
  logic [DATA_W-1:0]     pdata_q, pdata_d;
  logic [1:0]            ptag_q, ptag_d;
  logic [DATA_W-1:0]     op2_q, op2_d;
  logic [CMD_W-1:0]      cmd_tbl_q [NUM_TAGS];

  logic                  cpl_valid_q, cpl_valid_d;
  logic [1:0]            cpl_resp_q, cpl_resp_d;
  logic [DATA_W-1:0]     cpl_data_q, cpl_data_d;
  logic [1:0]            cpl_tag_q, cpl_tag_d;
  logic [CMD_W-1:0]      cpl_cmd_q, cpl_cmd_d;
  logic                  spur_q, spur_d;

  logic [NUM_TAGS-1:0]   busy;
  logic                  free_avail;
  logic [CALC_TAG_W-1:0] free_tag;
  logic                  alloc;
  logic                  handshake;
  logic                  resp_valid;
  logic                  resp_hit;
  logic                  to_valid;
  logic [CALC_TAG_W-1:0] to_tag;

  calc_tag_alloc #(
    .NUM_TAGS      (NUM_TAGS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tag_alloc (
    .PClk        (PClk),
    .reset       (reset),
    .alloc       (alloc),
    .free_req    (resp_hit),
    .free_req_tag(out_tag),
    .busy        (busy),
    .free_avail  (free_avail),
    .free_tag    (free_tag),
    .count       (outstanding),
    .to_valid    (to_valid),
    .to_tag      (to_tag)
  );

  // Gated by reset so the port never looks ready while reset is asserted.
  assign req_ready  = reset && (state_q == StIdle) && free_avail;
  assign handshake  = req_valid && req_ready;
  assign resp_valid = (out_resp != RespNone);
  assign resp_hit   = resp_valid && busy[out_tag];

  always_comb begin
    state_d = state_q;
    pcmd_d  = CMD_W'(CmdNop);
    pdata_d = '0;
    ptag_d  = '0;
    op2_d   = op2_q;
    alloc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          alloc   = 1'b1;
          pcmd_d  = req_cmd;
          pdata_d = req_op1;
          ptag_d  = free_tag;
          op2_d   = req_op2;
          state_d = StOp2;
        end
      end
      StOp2: begin
        pdata_d = op2_q;
        state_d = StIdle;
      end
    endcase
  end

  // Real responses take priority; a pending timeout retries next cycle.
  always_comb begin
    cpl_valid_d = 1'b0;
    cpl_resp_d  = cpl_resp_q;
    cpl_data_d  = cpl_data_q;
    cpl_tag_d   = cpl_tag_q;
    cpl_cmd_d   = cpl_cmd_q;
    spur_d      = spur_q | (resp_valid && !resp_hit);
    if (resp_hit) begin
      cpl_valid_d = 1'b1;
      cpl_resp_d  = out_resp;
      cpl_data_d  = out_data;
      cpl_tag_d   = out_tag;
      cpl_cmd_d   = cmd_tbl_q[out_tag];
    end else if (to_valid) begin
      cpl_valid_d = 1'b1;
      cpl_resp_d  = RespNone;
      cpl_data_d  = '0;
      cpl_tag_d   = to_tag;
      cpl_cmd_d   = cmd_tbl_q[to_tag];
    end
  end

  always_ff @(posedge PClk) begin
    if (!reset) begin
      state_q     <= StIdle;
      pcmd_q      <= '0;
      pdata_q     <= '0;
      ptag_q      <= '0;
      op2_q       <= '0;
      cpl_valid_q <= 1'b0;
      cpl_resp_q  <= '0;
      cpl_data_q  <= '0;
      cpl_tag_q   <= '0;
      cpl_cmd_q   <= '0;
      spur_q      <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) cmd_tbl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pcmd_q      <= pcmd_d;
      pdata_q     <= pdata_d;
      ptag_q      <= ptag_d;
      op2_q       <= op2_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_resp_q  <= cpl_resp_d;
      cpl_data_q  <= cpl_data_d;
      cpl_tag_q   <= cpl_tag_d;
      cpl_cmd_q   <= cpl_cmd_d;
      spur_q      <= spur_d;
      if (alloc) cmd_tbl_q[free_tag] <= req_cmd;
    end
  end

  assign PCmd         = pcmd_q;
  assign PData        = pdata_q;
  assign PTag         = ptag_q;
  assign cpl_valid    = cpl_valid_q;
  assign cpl_resp     = cpl_resp_q;
  assign cpl_data     = cpl_data_q;
  assign cpl_tag      = cpl_tag_q;
  assign cpl_cmd      = cpl_cmd_q;
  assign spurious_err = spur_q;

endmodule
